// File: rtl/rsa_sc_sequencer.sv
// Run sequencer for two redundant RSA key-generation copies: gates on prime
// verdicts, drains stale finishes, launches both copies and compares their latencies.
module rsa_sc_sequencer #(
   parameter int unsigned CNT_W   = 16,
   parameter int unsigned TIMEOUT = 4000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req,
   input  logic             prime_ok_1,
   input  logic             prime_ok_2,
   input  logic             finish_1,
   input  logic             finish_2,
   output logic             key_gen_start,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] lat_1,
   output logic [CNT_W-1:0] lat_2,
   output logic             leak,
   output logic             invalid,
   output logic             timeout
);

   localparam logic [CNT_W-1:0] LP_TIMEOUT = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] LP_ONES    = '1;

   typedef enum logic [2:0] {
      S_IDLE, S_CHECK, S_DRAIN, S_LAUNCH, S_RUN, S_REPORT
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
   logic             r_flag_1, r_flag_2, w_flag_1_nxt, w_flag_2_nxt;
   logic [CNT_W-1:0] r_lat_1, r_lat_2, w_lat_1_nxt, w_lat_2_nxt;
   logic             r_leak, r_invalid, r_timeout;
   logic             w_leak_nxt, w_invalid_nxt, w_timeout_nxt;
   logic             r_kgs, r_busy, r_done;
   logic             w_cap_1, w_cap_2;

   assign w_cnt_inc = r_cnt + CNT_W'(1);
   assign w_cap_1   = finish_1 & ~r_flag_1;
   assign w_cap_2   = finish_2 & ~r_flag_2;

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state and datapath updates
   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_flag_1_nxt  = r_flag_1;
      w_flag_2_nxt  = r_flag_2;
      w_lat_1_nxt   = r_lat_1;
      w_lat_2_nxt   = r_lat_2;
      w_leak_nxt    = r_leak;
      w_invalid_nxt = r_invalid;
      w_timeout_nxt = r_timeout;
      case (r_state)
         S_IDLE: begin
            if (req) w_state_nxt = S_CHECK;
         end
         S_CHECK: begin
            w_cnt_nxt     = '0;
            w_flag_1_nxt  = 1'b0;
            w_flag_2_nxt  = 1'b0;
            w_lat_1_nxt   = '0;
            w_lat_2_nxt   = '0;
            w_leak_nxt    = 1'b0;
            w_invalid_nxt = 1'b0;
            w_timeout_nxt = 1'b0;
            if (prime_ok_1 && prime_ok_2) begin
               w_state_nxt = S_DRAIN;
            end else begin
               w_invalid_nxt = 1'b1;
               w_state_nxt   = S_REPORT;
            end
         end
         S_DRAIN: begin
            w_cnt_nxt = w_cnt_inc;
            if (!finish_1 && !finish_2) begin
               w_state_nxt = S_LAUNCH;
            end else if (w_cnt_inc == LP_TIMEOUT) begin
               w_timeout_nxt = 1'b1;
               w_lat_1_nxt   = LP_ONES;
               w_lat_2_nxt   = LP_ONES;
               w_state_nxt   = S_REPORT;
            end
         end
         S_LAUNCH: begin
            w_cnt_nxt    = '0;
            w_flag_1_nxt = 1'b0;
            w_flag_2_nxt = 1'b0;
            w_state_nxt  = S_RUN;
         end
         S_RUN: begin
            // w_cnt_inc is the 1-based index of the current RUN cycle
            w_cnt_nxt = w_cnt_inc;
            if (w_cap_1) begin
               w_lat_1_nxt  = w_cnt_inc;
               w_flag_1_nxt = 1'b1;
            end
            if (w_cap_2) begin
               w_lat_2_nxt  = w_cnt_inc;
               w_flag_2_nxt = 1'b1;
            end
            if (w_flag_1_nxt && w_flag_2_nxt) begin
               w_leak_nxt  = (w_lat_1_nxt != w_lat_2_nxt);
               w_state_nxt = S_REPORT;
            end else if (w_cnt_inc == LP_TIMEOUT) begin
               w_timeout_nxt = 1'b1;
               if (!w_flag_1_nxt) w_lat_1_nxt = LP_ONES;
               if (!w_flag_2_nxt) w_lat_2_nxt = LP_ONES;
               w_state_nxt = S_REPORT;
            end
         end
         S_REPORT: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Datapath and registered control outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt     <= '0;
         r_flag_1  <= 1'b0;
         r_flag_2  <= 1'b0;
         r_lat_1   <= '0;
         r_lat_2   <= '0;
         r_leak    <= 1'b0;
         r_invalid <= 1'b0;
         r_timeout <= 1'b0;
         r_kgs     <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_cnt     <= w_cnt_nxt;
         r_flag_1  <= w_flag_1_nxt;
         r_flag_2  <= w_flag_2_nxt;
         r_lat_1   <= w_lat_1_nxt;
         r_lat_2   <= w_lat_2_nxt;
         r_leak    <= w_leak_nxt;
         r_invalid <= w_invalid_nxt;
         r_timeout <= w_timeout_nxt;
         r_kgs     <= (w_state_nxt == S_LAUNCH);
         r_busy    <= (w_state_nxt != S_IDLE);
         r_done    <= (w_state_nxt == S_REPORT);
      end
   end

   assign key_gen_start = r_kgs;
   assign busy          = r_busy;
   assign done          = r_done;
   assign lat_1         = r_lat_1;
   assign lat_2         = r_lat_2;
   assign leak          = r_leak;
   assign invalid       = r_invalid;
   assign timeout       = r_timeout;

endmodule

// File: tb/tb_rsa_sc_sequencer.sv
// Bench for rsa_sc_sequencer: each run's timeline and results are predicted
// from the run parameters (prime verdicts, drain lengths, finish cycles).
module tb_rsa_sc_sequencer;

   localparam int unsigned CNT_W = 16;
   localparam int          TO    = 50;
   localparam logic [CNT_W-1:0] ONES = '1;

   logic clk = 1'b0;
   logic rst, req, prime_ok_1, prime_ok_2, finish_1, finish_2;
   logic key_gen_start, busy, done, leak, invalid, timeout;
   logic [CNT_W-1:0] lat_1, lat_2;

   int checks = 0;
   int errors = 0;

   // Result values expected to be held from the previous run
   logic [CNT_W-1:0] h_lat_1, h_lat_2;
   logic h_leak, h_inv, h_to;

   rsa_sc_sequencer #(.CNT_W(CNT_W), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .req(req),
      .prime_ok_1(prime_ok_1), .prime_ok_2(prime_ok_2),
      .finish_1(finish_1), .finish_2(finish_2),
      .key_gen_start(key_gen_start), .busy(busy), .done(done),
      .lat_1(lat_1), .lat_2(lat_2),
      .leak(leak), .invalid(invalid), .timeout(timeout)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; req = 1'b1;
      prime_ok_1 = 1'b1; prime_ok_2 = 1'b1;
      finish_1 = 1'($urandom_range(0, 1)); finish_2 = 1'($urandom_range(0, 1));
      repeat (3) step();
      checks++;
      if ({key_gen_start, busy, done, leak, invalid, timeout} !== 6'b0) begin
         errors++;
         $display("FAIL reset_flags got kgs/busy/done/leak/inv/to=%b exp 000000",
                  {key_gen_start, busy, done, leak, invalid, timeout});
      end
      checks++;
      if (lat_1 !== '0 || lat_2 !== '0) begin
         errors++;
         $display("FAIL reset_lat got %h/%h exp 0000/0000", lat_1, lat_2);
      end
      rst = 1'b0; req = 1'b0;
      step();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_priority got busy=%b exp 0", busy);
      end
      h_lat_1 = '0; h_lat_2 = '0; h_leak = 1'b0; h_inv = 1'b0; h_to = 1'b0;
   endtask

   // One request from IDLE to IDLE. d1/d2: cycles each finish stays high while
   // draining; f1/f2: RUN cycle each finish rises (>TO means never);
   // rst_run>0 applies a reset on that RUN cycle instead of completing.
   task automatic do_run(input string name, input bit p1, input bit p2,
                         input int d1, input int d2, input int f1, input int f2,
                         input int rst_run);
      bit valid, c1, c2, chk_lat;
      int dmax, t_launch, t_report, e_run, n;
      logic [CNT_W-1:0] e_lat_1, e_lat_2;
      logic e_leak, e_inv, e_to, e_busy, e_kgs, e_done;
      logic [CNT_W-1:0] x_lat_1, x_lat_2;
      logic x_leak, x_inv, x_to;

      valid    = p1 && p2;
      dmax     = (d1 > d2) ? d1 : d2;
      t_launch = -1;
      e_lat_1 = '0; e_lat_2 = '0; e_leak = 1'b0; e_inv = 1'b0; e_to = 1'b0;
      if (!valid) begin
         e_inv    = 1'b1;
         t_report = 2;
      end else if (dmax >= TO) begin
         e_to = 1'b1; e_lat_1 = ONES; e_lat_2 = ONES;
         t_report = TO + 2;
      end else begin
         t_launch = dmax + 3;
         c1 = (f1 <= TO);
         c2 = (f2 <= TO);
         e_lat_1 = c1 ? CNT_W'(f1) : ONES;
         e_lat_2 = c2 ? CNT_W'(f2) : ONES;
         if (c1 && c2) begin
            e_run  = (f1 > f2) ? f1 : f2;
            e_leak = (f1 != f2);
         end else begin
            e_run = TO;
            e_to  = 1'b1;
         end
         t_report = t_launch + e_run + 1;
      end

      for (int t = 0; t <= t_report + 1; t++) begin
         // stimulus for cycle t
         if (t == 0)             req = 1'b1;
         else if (t <= t_report) req = 1'($urandom_range(0, 1));
         else                    req = 1'b0;
         if (t == 1) begin
            prime_ok_1 = p1; prime_ok_2 = p2;
         end else begin
            prime_ok_1 = 1'($urandom_range(0, 1)); prime_ok_2 = 1'($urandom_range(0, 1));
         end
         if (t_launch > 0 && t > t_launch && t <= t_report) begin
            n = t - t_launch;
            finish_1 = (n >= f1);
            finish_2 = (n >= f2);
         end else begin
            finish_1 = (d1 > 0) && (t - 1 <= d1);
            finish_2 = (d2 > 0) && (t - 1 <= d2);
         end

         // expected outputs in cycle t
         e_busy = (t >= 1 && t <= t_report);
         e_kgs  = (t == t_launch);
         e_done = (t == t_report);
         checks++;
         if ({key_gen_start, busy, done} !== {e_kgs, e_busy, e_done}) begin
            errors++;
            $display("FAIL %s_ctl t=%0d got kgs/busy/done=%b%b%b exp %b%b%b", name, t,
                     key_gen_start, busy, done, e_kgs, e_busy, e_done);
         end
         chk_lat = 1'b1;
         if (t <= 1) begin
            x_lat_1 = h_lat_1; x_lat_2 = h_lat_2; x_leak = h_leak; x_inv = h_inv; x_to = h_to;
         end else if (t < t_report) begin
            x_lat_1 = '0; x_lat_2 = '0; x_leak = 1'b0; x_inv = 1'b0; x_to = 1'b0;
            chk_lat = (t == 2);
         end else begin
            x_lat_1 = e_lat_1; x_lat_2 = e_lat_2; x_leak = e_leak; x_inv = e_inv; x_to = e_to;
         end
         checks++;
         if ({leak, invalid, timeout} !== {x_leak, x_inv, x_to}) begin
            errors++;
            $display("FAIL %s_flags t=%0d got leak/inv/to=%b%b%b exp %b%b%b", name, t,
                     leak, invalid, timeout, x_leak, x_inv, x_to);
         end
         if (chk_lat) begin
            checks++;
            if (lat_1 !== x_lat_1 || lat_2 !== x_lat_2) begin
               errors++;
               $display("FAIL %s_lat t=%0d got %0d/%0d exp %0d/%0d", name, t,
                        lat_1, lat_2, x_lat_1, x_lat_2);
            end
         end

         if (rst_run > 0 && t_launch > 0 && t == t_launch + rst_run) begin
            rst = 1'b1;
            step();
            rst = 1'b0; req = 1'b0; finish_1 = 1'b0; finish_2 = 1'b0;
            checks++;
            if ({key_gen_start, busy, done, leak, invalid, timeout} !== 6'b0 ||
                lat_1 !== '0 || lat_2 !== '0) begin
               errors++;
               $display("FAIL %s_rst got ctl=%b lat=%0d/%0d exp all zero", name,
                        {key_gen_start, busy, done, leak, invalid, timeout}, lat_1, lat_2);
            end
            step();
            checks++;
            if (busy !== 1'b0) begin
               errors++;
               $display("FAIL %s_rst_idle got busy=%b exp 0", name, busy);
            end
            h_lat_1 = '0; h_lat_2 = '0; h_leak = 1'b0; h_inv = 1'b0; h_to = 1'b0;
            return;
         end
         step();
      end
      h_lat_1 = e_lat_1; h_lat_2 = e_lat_2; h_leak = e_leak; h_inv = e_inv; h_to = e_to;
   endtask

   task automatic test_directed();
      do_run("same37",     1, 1, 0, 0, 37, 37, 0);
      do_run("diff37_41",  1, 1, 0, 0, 37, 41, 0);
      do_run("bad_prime2", 1, 0, 0, 0, 5, 5, 0);
      do_run("bad_prime1", 0, 1, 3, 0, 5, 5, 0);
      do_run("to_no_f2",   1, 1, 0, 0, 20, 100, 0);
      do_run("to_none",    1, 1, 0, 0, 70, 90, 0);
      do_run("simul_3",    1, 1, 0, 0, 3, 3, 0);
   endtask

   task automatic test_drain();
      do_run("drain7",     1, 1, 7, 0, 5, 9, 0);
      do_run("drain_both", 1, 1, 4, 11, 2, 1, 0);
      do_run("drain_49",   1, 1, 49, 0, 6, 6, 0);
      do_run("drain_to",   1, 1, 60, 0, 5, 5, 0);
      do_run("drain_eq",   1, 1, 0, 50, 5, 5, 0);
   endtask

   task automatic test_boundary();
      do_run("both_at_to", 1, 1, 0, 0, 50, 50, 0);
      do_run("f1_at_to",   1, 1, 0, 0, 50, 51, 0);
      do_run("first_cyc",  1, 1, 0, 0, 1, 1, 0);
   endtask

   task automatic test_reset_midrun();
      do_run("rst_run10", 1, 1, 0, 0, 37, 37, 10);
      do_run("after_rst", 1, 1, 0, 0, 12, 3, 0);
   endtask

   task automatic test_random();
      bit p1, p2;
      int d1, d2, f1, f2;
      for (int i = 0; i < 40; i++) begin
         p1 = ($urandom_range(0, 7) != 0);
         p2 = ($urandom_range(0, 7) != 0);
         d1 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 55)) : 0;
         d2 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 55)) : 0;
         f1 = int'($urandom_range(1, 60));
         f2 = ($urandom_range(0, 2) == 0) ? f1 : int'($urandom_range(1, 60));
         do_run("rand", p1, p2, d1, d2, f1, f2, 0);
      end
   endtask

   initial begin
      rst = 1'b1; req = 1'b0; prime_ok_1 = 1'b0; prime_ok_2 = 1'b0;
      finish_1 = 1'b0; finish_2 = 1'b0;
      test_reset();
      test_directed();
      test_drain();
      test_boundary();
      test_reset_midrun();
      test_random();
      test_reset();
      do_run("post_reset", 1, 1, 0, 0, 8, 15, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog got no completion exp finish before limit");
      $fatal(1);
   end

endmodule
